master_slave_ff: RTL and testbench

//   Parameterised-width edge-triggered register built as a master-slave latch pair.

---
 rtl/master_slave_ff_if.sv | 20 ++
 rtl/master_slave_ff.sv | 59 +++++
 tb/tb_master_slave_ff.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/master_slave_ff_if.sv
// Data bundle for one master_slave_ff stage: d/en driven by the producer, q returned by the register.
interface master_slave_ff_if #(
    parameter int unsigned WIDTH = 32
);
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic             en;

    modport master (
        output d,
        output en,
        input  q
    );

    modport slave (
        input  d,
        input  en,
        output q
    );
endinterface

// File: rtl/master_slave_ff.sv
// Edge-triggered pipeline register built from per-bit master/slave latch pairs.
// Optional load enable (port en, last in the list) is compiled in when MSFF_HOLD_EN is defined.
module master_slave_ff #(
    parameter int unsigned      WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
`ifdef MSFF_HOLD_EN
    ,
    input  logic             en
`endif
);

    logic [WIDTH-1:0] next_d;
    logic [WIDTH-1:0] slave_bus_s;

    // Next-state select: reset wins, then hold (when enabled), then new data.
    always_comb begin
        next_d = d;
        if (rst) begin
            next_d = RESET_VALUE;
        end
`ifdef MSFF_HOLD_EN
        else if (!en) begin
            next_d = slave_bus_s;
        end
`endif
        else begin
            next_d = d;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic master_q = RESET_VALUE[i];
        logic slave_q  = RESET_VALUE[i];

        // Master latch: open during the low phase so it settles before the rising edge.
        always_latch begin
            if (!clk) begin
                master_q <= next_d[i];
            end
        end

        // Slave latch: open during the high phase, exposing the value captured by the master.
        always_latch begin
            if (clk) begin
                slave_q <= master_q;
            end
        end

        assign slave_bus_s[i] = slave_q;
    end

    assign q = slave_bus_s;

endmodule

// File: tb/tb_master_slave_ff.sv
// Scoreboard bench for master_slave_ff: a 19-bit instance (reset 0) and a 12-bit instance (reset 12'hABC).
module tb_master_slave_ff;

    logic clk;
    logic rst19;
    logic rst12;

    master_slave_ff_if #(.WIDTH(19)) bus19 ();
    master_slave_ff_if #(.WIDTH(12)) bus12 ();

    master_slave_ff #(.WIDTH(19), .RESET_VALUE(19'd0)) dut19 (
        .clk (clk),
        .rst (rst19),
        .d   (bus19.d),
        .q   (bus19.q)
`ifdef MSFF_HOLD_EN
        ,
        .en  (bus19.en)
`endif
    );

    master_slave_ff #(.WIDTH(12), .RESET_VALUE(12'hABC)) dut12 (
        .clk (clk),
        .rst (rst12),
        .d   (bus12.d),
        .q   (bus12.q)
`ifdef MSFF_HOLD_EN
        ,
        .en  (bus12.en)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    logic [18:0] sb19[$];
    logic [11:0] sb12[$];
    logic [18:0] e19;
    logic [11:0] e12;

    task automatic test_reset();
        #1;
        sb19.push_back(19'd0);
        sb12.push_back(12'hABC);
        e19 = sb19.pop_front();
        tests++;
        if (bus19.q !== e19) begin
            $display("FAIL powerup19 got=%0h exp=%0h", bus19.q, e19);
            fails++;
        end
        e12 = sb12.pop_front();
        tests++;
        if (bus12.q !== e12) begin
            $display("FAIL powerup12 got=%0h exp=%0h", bus12.q, e12);
            fails++;
        end
    endtask

    task automatic test_load();
        sb19.push_back(19'd110);
        @(posedge clk); #1;
        e19 = sb19.pop_front();
        tests++;
        if (bus19.q !== e19) begin
            $display("FAIL load110 got=%0d exp=%0d", bus19.q, e19);
            fails++;
        end
    endtask

    task automatic test_mid_cycle();
        @(negedge clk); #2;
        bus19.d = 19'd12400;
        sb19.push_back(19'd110);
        #1;
        e19 = sb19.pop_front();
        tests++;
        if (bus19.q !== e19) begin
            $display("FAIL midcycle_hold got=%0d exp=%0d", bus19.q, e19);
            fails++;
        end
        sb19.push_back(19'd12400);
        @(posedge clk); #1;
        e19 = sb19.pop_front();
        tests++;
        if (bus19.q !== e19) begin
            $display("FAIL midcycle_load got=%0d exp=%0d", bus19.q, e19);
            fails++;
        end
    endtask

    task automatic test_sync_reset();
        @(negedge clk); #1;
        rst19 = 1'b1;
        sb19.push_back(19'd12400);
        #1;
        e19 = sb19.pop_front();
        tests++;
        if (bus19.q !== e19) begin
            $display("FAIL rst_not_async got=%0d exp=%0d", bus19.q, e19);
            fails++;
        end
        sb19.push_back(19'd0);
        @(posedge clk); #1;
        e19 = sb19.pop_front();
        tests++;
        if (bus19.q !== e19) begin
            $display("FAIL rst_edge got=%0d exp=%0d", bus19.q, e19);
            fails++;
        end
        rst19 = 1'b0;
        sb19.push_back(19'd12400);
        @(posedge clk); #1;
        e19 = sb19.pop_front();
        tests++;
        if (bus19.q !== e19) begin
            $display("FAIL rst_release got=%0d exp=%0d", bus19.q, e19);
            fails++;
        end
    endtask

    task automatic test_reset_value();
        rst12 = 1'b1;
        bus12.d = 12'd555;
        for (int i = 0; i < 3; i++) begin
            sb12.push_back(12'hABC);
            @(posedge clk); #1;
            e12 = sb12.pop_front();
            tests++;
            if (bus12.q !== e12) begin
                $display("FAIL rstval_cycle%0d got=%0h exp=%0h", i, bus12.q, e12);
                fails++;
            end
        end
        rst12 = 1'b0;
        bus12.d = 12'd72;
        sb12.push_back(12'd72);
        @(posedge clk); #1;
        e12 = sb12.pop_front();
        tests++;
        if (bus12.q !== e12) begin
            $display("FAIL rstval_release got=%0d exp=%0d", bus12.q, e12);
            fails++;
        end
    endtask

`ifdef MSFF_HOLD_EN
    task automatic test_hold_en();
        bus12.en = 1'b0;
        bus12.d  = 12'd100;
        sb12.push_back(12'd72);
        @(posedge clk); #1;
        e12 = sb12.pop_front();
        tests++;
        if (bus12.q !== e12) begin
            $display("FAIL en_hold got=%0d exp=%0d", bus12.q, e12);
            fails++;
        end
        bus12.en = 1'b1;
        sb12.push_back(12'd100);
        @(posedge clk); #1;
        e12 = sb12.pop_front();
        tests++;
        if (bus12.q !== e12) begin
            $display("FAIL en_load got=%0d exp=%0d", bus12.q, e12);
            fails++;
        end
        bus12.en = 1'b0;
        rst12 = 1'b1;
        sb12.push_back(12'hABC);
        @(posedge clk); #1;
        e12 = sb12.pop_front();
        tests++;
        if (bus12.q !== e12) begin
            $display("FAIL en_rst_priority got=%0h exp=%0h", bus12.q, e12);
            fails++;
        end
        rst12 = 1'b0;
        bus12.en = 1'b1;
    endtask
`endif

    task automatic test_high_phase();
        bus19.d = 19'd300;
        sb19.push_back(19'd300);
        @(posedge clk); #1;
        e19 = sb19.pop_front();
        tests++;
        if (bus19.q !== e19) begin
            $display("FAIL highphase_pre got=%0d exp=%0d", bus19.q, e19);
            fails++;
        end
        // Still inside the high phase: toggle d and confirm q ignores it.
        bus19.d = 19'd5;
        #1 bus19.d = 19'd9;
        #1 bus19.d = 19'd5;
        #1;
        sb19.push_back(19'd300);
        e19 = sb19.pop_front();
        tests++;
        if (bus19.q !== e19) begin
            $display("FAIL highphase_toggle got=%0d exp=%0d", bus19.q, e19);
            fails++;
        end
        sb19.push_back(19'd5);
        @(posedge clk); #1;
        e19 = sb19.pop_front();
        tests++;
        if (bus19.q !== e19) begin
            $display("FAIL highphase_next got=%0d exp=%0d", bus19.q, e19);
            fails++;
        end
    endtask

    task automatic test_back_to_back();
        logic [18:0] m19;
        logic [11:0] m12;
        logic        r19;
        logic        r12;
        // Known starting point for both models.
        rst19 = 1'b0;
        rst12 = 1'b0;
        bus19.en = 1'b1;
        bus12.en = 1'b1;
        bus19.d = 19'h5A5A5;
        bus12.d = 12'h3C3;
        sb19.push_back(19'h5A5A5);
        sb12.push_back(12'h3C3);
        @(posedge clk); #1;
        m19 = sb19.pop_front();
        m12 = sb12.pop_front();
        tests++;
        if (bus19.q !== m19 || bus12.q !== m12) begin
            $display("FAIL b2b_start got=%0h/%0h exp=%0h/%0h", bus19.q, bus12.q, m19, m12);
            fails++;
        end
        for (int i = 0; i < 24; i++) begin
            bus19.d = 19'($urandom);
            bus12.d = 12'($urandom);
            r19 = ($urandom_range(0, 5) == 0);
            r12 = ($urandom_range(0, 5) == 0);
            rst19 = r19;
            rst12 = r12;
`ifdef MSFF_HOLD_EN
            bus19.en = 1'($urandom_range(0, 1));
            bus12.en = 1'($urandom_range(0, 1));
`endif
            m19 = r19 ? 19'd0 : (bus19.en ? bus19.d : m19);
            m12 = r12 ? 12'hABC : (bus12.en ? bus12.d : m12);
            sb19.push_back(m19);
            sb12.push_back(m12);
            @(posedge clk); #1;
            e19 = sb19.pop_front();
            tests++;
            if (bus19.q !== e19) begin
                $display("FAIL b2b19_%0d got=%0h exp=%0h", i, bus19.q, e19);
                fails++;
            end
            e12 = sb12.pop_front();
            tests++;
            if (bus12.q !== e12) begin
                $display("FAIL b2b12_%0d got=%0h exp=%0h", i, bus12.q, e12);
                fails++;
            end
        end
        rst19 = 1'b0;
        rst12 = 1'b0;
    endtask

    initial begin
        rst19    = 1'b0;
        rst12    = 1'b0;
        bus19.d  = 19'd110;
        bus19.en = 1'b1;
        bus12.d  = 12'd0;
        bus12.en = 1'b1;
        test_reset();
        test_load();
        test_mid_cycle();
        test_sync_reset();
        test_reset_value();
`ifdef MSFF_HOLD_EN
        test_hold_en();
`endif
        test_high_phase();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
